// File: rtl/esm_dispatch_alloc.sv
// esm_dispatch_alloc: issue-buffer entry allocation, tag wakeup and issue-free tracking.
// Build option ESM_ALLOC_RR_EN: allocate circularly from a rotating pointer instead of lowest-free.
module esm_dispatch_alloc #(
  parameter int bs   = 16,
  parameter int TAGW = 6,
  localparam int IW  = $clog2(bs)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_disp_valid,
  output logic            o_disp_ready,
  input  logic [TAGW-1:0] i_disp_src_tag,
  input  logic            i_disp_src_rdy,
  output logic [IW-1:0]   o_alloc_index,
  input  logic            i_wake_valid,
  input  logic [TAGW-1:0] i_wake_tag,
  input  logic            i_issue_valid,
  input  logic [IW-1:0]   i_issue_index,
  output logic [bs-1:0]   o_ready_positions,
  output logic [IW:0]     o_occupancy,
  output logic            o_full,
  output logic            o_empty
);

  logic [bs-1:0]   r_vld;
  logic [bs-1:0]   r_rdy;
  logic [TAGW-1:0] r_tag [bs];
  logic [IW:0]     r_occ;

  logic            w_full;
  logic            w_fire;
  logic            w_issue_ok;
  logic            w_new_rdy;
  logic [IW-1:0]   w_alloc;

`ifdef ESM_ALLOC_RR_EN
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] w_probe;

  // Scan from farthest to nearest so the first free slot at/after the pointer wins.
  always_comb begin
    w_alloc = '0;
    w_probe = '0;
    for (int k = bs - 1; k >= 0; k--) begin
      w_probe = r_rr_ptr + IW'(k);
      if (!r_vld[w_probe]) w_alloc = w_probe;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_rr_ptr <= '0;
    else if (w_fire) r_rr_ptr <= w_alloc + IW'(1);
  end
`else
  always_comb begin
    w_alloc = '0;
    for (int k = bs - 1; k >= 0; k--) begin
      if (!r_vld[k]) w_alloc = IW'(k);
    end
  end
`endif

  assign w_full     = (r_occ == (IW+1)'(bs));
  assign w_fire     = i_disp_valid & o_disp_ready;
  assign w_issue_ok = i_issue_valid & r_vld[i_issue_index] & r_rdy[i_issue_index];
  assign w_new_rdy  = i_disp_src_rdy | (i_wake_valid & (i_wake_tag == i_disp_src_tag));

  // An issued entry is always valid while the allocated one is always free, so they never collide.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= '0;
      r_rdy <= '0;
      r_occ <= '0;
      for (int i = 0; i < bs; i++) r_tag[i] <= '0;
    end else begin
      for (int i = 0; i < bs; i++) begin
        if (i_wake_valid && r_vld[i] && !r_rdy[i] && (r_tag[i] == i_wake_tag))
          r_rdy[i] <= 1'b1;
      end
      if (w_fire) begin
        r_vld[w_alloc] <= 1'b1;
        r_rdy[w_alloc] <= w_new_rdy;
        r_tag[w_alloc] <= i_disp_src_tag;
      end
      if (w_issue_ok) begin
        r_vld[i_issue_index] <= 1'b0;
        r_rdy[i_issue_index] <= 1'b0;
      end
      r_occ <= r_occ + {{IW{1'b0}}, w_fire} - {{IW{1'b0}}, w_issue_ok};
    end
  end

  assign o_disp_ready      = ~w_full & ~i_rst;
  assign o_alloc_index     = w_alloc;
  assign o_ready_positions = r_vld & r_rdy;
  assign o_occupancy       = r_occ;
  assign o_full            = w_full;
  assign o_empty           = (r_occ == '0);

endmodule

// File: tb/tb_esm_dispatch_alloc.sv
// tb_esm_dispatch_alloc: directed and random stimulus against an entry-array reference model.
module tb_esm_dispatch_alloc;
  localparam int BS   = 16;
  localparam int TAGW = 6;
  localparam int IW   = 4;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b0;
  logic            i_disp_valid = 1'b0;
  logic            o_disp_ready;
  logic [TAGW-1:0] i_disp_src_tag = '0;
  logic            i_disp_src_rdy = 1'b0;
  logic [IW-1:0]   o_alloc_index;
  logic            i_wake_valid = 1'b0;
  logic [TAGW-1:0] i_wake_tag = '0;
  logic            i_issue_valid = 1'b0;
  logic [IW-1:0]   i_issue_index = '0;
  logic [BS-1:0]   o_ready_positions;
  logic [IW:0]     o_occupancy;
  logic            o_full;
  logic            o_empty;

  esm_dispatch_alloc #(.bs(BS), .TAGW(TAGW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_disp_valid(i_disp_valid), .o_disp_ready(o_disp_ready),
    .i_disp_src_tag(i_disp_src_tag), .i_disp_src_rdy(i_disp_src_rdy),
    .o_alloc_index(o_alloc_index),
    .i_wake_valid(i_wake_valid), .i_wake_tag(i_wake_tag),
    .i_issue_valid(i_issue_valid), .i_issue_index(i_issue_index),
    .o_ready_positions(o_ready_positions), .o_occupancy(o_occupancy),
    .o_full(o_full), .o_empty(o_empty)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int compared = 0;
  int mismatched = 0;

  // Reference model: the buffer as plain per-entry arrays.
  bit            m_vld [BS];
  bit            m_rdy [BS];
  bit [TAGW-1:0] m_tag [BS];
  int            m_ptr = 0;
  bit            m_known = 0;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < BS; i++) n += m_vld[i];
    return n;
  endfunction

  function automatic int m_alloc();
    for (int k = 0; k < BS; k++) begin
      int j = (m_ptr + k) % BS;
      if (!m_vld[j]) return j;
    end
    return 0;
  endfunction

  function automatic logic [BS-1:0] m_rp();
    logic [BS-1:0] v = '0;
    for (int i = 0; i < BS; i++) v[i] = m_vld[i] & m_rdy[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit dv, input int stag, input bit srdy,
                      input bit wv, input int wtag, input bit iv, input int iidx);
    int  a;
    bit  fire;
    bit  iss;
    i_rst          = rst;
    i_disp_valid   = dv;
    i_disp_src_tag = TAGW'(stag);
    i_disp_src_rdy = srdy;
    i_wake_valid   = wv;
    i_wake_tag     = TAGW'(wtag);
    i_issue_valid  = iv;
    i_issue_index  = IW'(iidx);
    #2;
    if (m_known) begin
      chk("disp_ready", {31'b0, o_disp_ready}, {31'b0, (!rst && m_count() != BS)});
      chk("alloc_index", {28'b0, o_alloc_index}, (m_count() == BS) ? 0 : m_alloc());
    end
    @(posedge i_clk);
    if (rst) begin
      for (int i = 0; i < BS; i++) begin
        m_vld[i] = 0;
        m_rdy[i] = 0;
      end
      m_ptr   = 0;
      m_known = 1;
    end else begin
      a    = m_alloc();
      fire = dv && (m_count() != BS);
      iss  = iv && m_vld[iidx] && m_rdy[iidx];
      if (wv)
        for (int i = 0; i < BS; i++)
          if (m_vld[i] && m_tag[i] == TAGW'(wtag)) m_rdy[i] = 1;
      if (fire) begin
        m_vld[a] = 1;
        m_tag[a] = TAGW'(stag);
        m_rdy[a] = srdy || (wv && wtag == stag);
`ifdef ESM_ALLOC_RR_EN
        m_ptr = (a + 1) % BS;
`endif
      end
      if (iss) begin
        m_vld[iidx] = 0;
        m_rdy[iidx] = 0;
      end
    end
    #1;
    chk("ready_positions", {16'b0, o_ready_positions}, {16'b0, m_rp()});
    chk("occupancy", {27'b0, o_occupancy}, m_count());
    chk("full", {31'b0, o_full}, {31'b0, m_count() == BS});
    chk("empty", {31'b0, o_empty}, {31'b0, m_count() == 0});
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 1, 0, 0, 0, 0);
    chk("rst_disp_ready", {31'b0, o_disp_ready}, 0);
    chk("rst_empty", {31'b0, o_empty}, 1);
    idle();

    for (int i = 0; i < BS; i++) step(0, 1, i, 1, 0, 0, 0, 0);
    chk("fill_rp", {16'b0, o_ready_positions}, 32'h0000_FFFF);
    chk("fill_full", {31'b0, o_full}, 1);
    chk("fill_disp_ready", {31'b0, o_disp_ready}, 0);
    step(0, 1, 7, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 3);
    chk("issue3_occ", {27'b0, o_occupancy}, 15);
    chk("issue3_ready", {31'b0, o_disp_ready}, 1);
    chk("issue3_alloc", {28'b0, o_alloc_index}, 3);
    step(0, 1, 2, 1, 0, 0, 0, 0);

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 0, 0, 0, 0, 0);
    chk("tag5_not_ready", {16'b0, o_ready_positions}, 0);
    step(0, 0, 0, 0, 1, 6, 0, 0);
    chk("wake6_nochange", {16'b0, o_ready_positions}, 0);
    step(0, 0, 0, 0, 1, 5, 0, 0);
    chk("wake5_set", {16'b0, o_ready_positions}, 1);
    step(0, 1, 9, 0, 1, 9, 0, 0);
    chk("bypass9", {16'b0, o_ready_positions}, 3);
    step(0, 1, 12, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 2);
    chk("issue_not_ready_occ", {27'b0, o_occupancy}, 3);
    step(0, 0, 0, 0, 0, 0, 1, 10);
    chk("issue_invalid_rp", {16'b0, o_ready_positions}, 3);
    step(0, 0, 0, 0, 1, 9, 1, 1);
    chk("issue_wake_rp", {16'b0, o_ready_positions}, 1);
    chk("issue_wake_occ", {27'b0, o_occupancy}, 2);

    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < BS; i++) step(0, 1, i, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, i);
    for (int i = 0; i < 4; i++) step(0, 1, 20, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 6);
`ifdef ESM_ALLOC_RR_EN
    chk("rr_first", {28'b0, o_alloc_index}, 6);
`else
    chk("lowest_first", {28'b0, o_alloc_index}, 1);
`endif
    step(0, 1, 21, 1, 0, 0, 0, 0);
`ifdef ESM_ALLOC_RR_EN
    chk("rr_second", {28'b0, o_alloc_index}, 1);
`else
    chk("lowest_second", {28'b0, o_alloc_index}, 6);
`endif

    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 9) < 7), $urandom_range(0, 7), ($urandom_range(0, 9) < 3),
           $urandom_range(0, 1), $urandom_range(0, 7),
           ($urandom_range(0, 9) < 6), $urandom_range(0, BS - 1));
    end

    for (int i = 0; i < 6; i++) step(0, 1, i, i % 2, 0, 0, 0, 0);
    step(1, 1, 4, 1, 1, 4, 1, 0);
    chk("mid_rst_occ", {27'b0, o_occupancy}, 0);
    chk("mid_rst_rp", {16'b0, o_ready_positions}, 0);
    chk("mid_rst_empty", {31'b0, o_empty}, 1);
    chk("mid_rst_full", {31'b0, o_full}, 0);
    chk("mid_rst_disp_ready", {31'b0, o_disp_ready}, 0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
